// File: rtl/led_alarm_pkg.sv
// Shared definitions for the status-LED alarm sequencer: FSM state encoding
// and the default blink timing used by the top level.
package led_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Default phase lengths in clk cycles (0.25 s blink, 0.75 s gap at 100 MHz)
    localparam int L_TIME_DEF   = 25_000_000;
    localparam int GAP_TIME_DEF = 75_000_000;
    localparam int CNT_W_DEF    = 27;

endpackage

// File: rtl/led_alarm_prio.sv
// Combinational lowest-set-bit priority encoder: reports the index of the
// lowest asserted request and whether any request is asserted.
module led_alarm_prio #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_alarm_ctrl.sv
// Status LED sequencer: latches error sources into sticky pending flags and
// blinks (index+1) pulses for the lowest pending source, followed by a steady
// high gap, repeating while anything is pending. Steady high means healthy.
module led_alarm_ctrl
    import led_alarm_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int L_TIME   = L_TIME_DEF,
    parameter int GAP_TIME = GAP_TIME_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int IDX_W   = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] err_in,
    input  logic             err_clr,
    output logic             led,
    output logic             err_active,
    output logic [IDX_W-1:0] err_code
);

    localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(L_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TIME - 1);

    state_t             state, state_nx;
    logic [N_SRC-1:0]   pend, pend_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W:0]     pulse, pulse_nx;
    logic [IDX_W-1:0]   code_nx;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    // Arbitration always looks at the registered flags; the FSM only uses the
    // result when leaving IDLE or finishing a gap, so codes are never cut short
    led_alarm_prio #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (pend),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // Sticky pending flags; a source asserted together with the clear survives
    always_comb begin
        pend_nx = err_clr ? err_in : (pend | err_in);
    end

    // Next-state logic for the blink sequence, with clear acting as an abort
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = pulse;
        code_nx  = err_code;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (arb_vld) begin
                    code_nx  = arb_idx;
                    pulse_nx = '0;
                    state_nx = ST_OFF;
                end
            end
            ST_OFF: begin
                if (cnt == L_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_ON;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_ON: begin
                if (cnt == L_LAST) begin
                    cnt_nx = '0;
                    if (pulse == {1'b0, err_code}) begin
                        state_nx = ST_GAP;
                    end else begin
                        pulse_nx = pulse + (IDX_W + 1)'(1);
                        state_nx = ST_OFF;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx = '0;
                    if (arb_vld) begin
                        code_nx  = arb_idx;
                        pulse_nx = '0;
                        state_nx = ST_OFF;
                    end else begin
                        code_nx  = '0;
                        pulse_nx = '0;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                pulse_nx = '0;
                code_nx  = '0;
            end
        endcase
        // A clear while a code is showing drops straight back to IDLE
        if (err_clr && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            pulse_nx = '0;
            code_nx  = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend       <= '0;
            cnt        <= '0;
            pulse      <= '0;
            led        <= 1'b1;
            err_active <= 1'b0;
            err_code   <= '0;
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            cnt        <= cnt_nx;
            pulse      <= pulse_nx;
            led        <= (state_nx != ST_OFF);
            err_active <= |pend_nx;
            err_code   <= code_nx;
        end
    end

endmodule

// File: tb/tb_led_alarm_ctrl.sv
// Self-checking bench for led_alarm_ctrl with short blink timing.
module tb_led_alarm_ctrl;

    localparam int N_SRC    = 4;
    localparam int L_TIME   = 4;
    localparam int GAP_TIME = 10;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] err_in = 4'd0;
    logic       err_clr = 1'b0;
    logic       led;
    logic       err_active;
    logic [1:0] err_code;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending flags plus "which code, how far into it"
    logic [3:0] m_pend;
    bit         m_act;
    int         m_code;
    int         m_pos;

    always #5 clk = ~clk;

    led_alarm_ctrl #(
        .N_SRC    (N_SRC),
        .L_TIME   (L_TIME),
        .GAP_TIME (GAP_TIME),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .err_in     (err_in),
        .err_clr    (err_clr),
        .led        (led),
        .err_active (err_active),
        .err_code   (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic int period(input int k);
        return 2 * (k + 1) * L_TIME + GAP_TIME;
    endfunction

    function automatic logic exp_led();
        if (!m_act) return 1'b1;
        if (m_pos < 2 * (m_code + 1) * L_TIME) return ((m_pos / L_TIME) % 2) != 0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pend = 4'd0;
        m_act  = 1'b0;
        m_code = 0;
        m_pos  = 0;
    endtask

    // Advance the model by one clock edge given the inputs sampled at it
    task automatic model_edge(input logic [3:0] ei, input logic clr);
        logic [3:0] p_old;
        p_old = m_pend;
        if (!m_act) begin
            if (p_old != 4'd0) begin
                m_act  = 1'b1;
                m_code = lowest(p_old);
                m_pos  = 0;
            end
        end else if (clr) begin
            m_act  = 1'b0;
            m_code = 0;
            m_pos  = 0;
        end else begin
            m_pos++;
            if (m_pos == period(m_code)) begin
                m_pos = 0;
                if (p_old != 4'd0) begin
                    m_code = lowest(p_old);
                end else begin
                    m_act  = 1'b0;
                    m_code = 0;
                end
            end
        end
        m_pend = clr ? ei : (p_old | ei);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".led"}, 32'(led), 32'(exp_led()));
        chk({tag, ".err_active"}, 32'(err_active), 32'(m_pend != 4'd0));
        chk({tag, ".err_code"}, 32'(err_code), m_act ? 32'(m_code) : 32'd0);
    endtask

    task automatic step(input logic [3:0] ei, input logic clr, input string tag);
        @(negedge clk);
        err_in  = ei;
        err_clr = clr;
        @(posedge clk);
        model_edge(ei, clr);
        #1;
        check_outs(tag);
    endtask

    task automatic clear_all();
        step(4'd0, 1'b1, "clear");
        step(4'd0, 1'b0, "clear_idle");
    endtask

    initial begin
        bit ok;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.led", 32'(led), 32'd1);
        chk("rst.err_active", 32'(err_active), 32'd0);
        chk("rst.err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle for 200 cycles
        repeat (200) step(4'd0, 1'b0, "idle");
        chk("idle.led_final", 32'(led), 32'd1);

        // 2: single pulse on source 2
        step(4'b0100, 1'b0, "t2_pulse");
        chk("t2.active_t1", 32'(err_active), 32'd1);
        chk("t2.led_t1", 32'(led), 32'd1);
        step(4'd0, 1'b0, "t2");
        chk("t2.led_t2", 32'(led), 32'd0);
        chk("t2.code_t2", 32'(err_code), 32'd2);
        repeat (80) step(4'd0, 1'b0, "t2");
        clear_all();

        // 3: sources 1 and 3 together, code 1 wins
        step(4'b1010, 1'b0, "t3_pulse");
        repeat (120) step(4'd0, 1'b0, "t3");
        chk("t3.code", 32'(err_code), 32'd1);
        clear_all();

        // 4: source 0 arriving during code 3 waits for the gap to end
        step(4'b1000, 1'b0, "t4_pulse");
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step(4'd0, 1'b0, "t4_wait");
            ok = m_act && (m_code == 3) && (m_pos == 9);
        end
        chk("t4.reach_off2", 32'(ok), 32'd1);
        step(4'b0001, 1'b0, "t4_inject");
        chk("t4.code_kept", 32'(err_code), 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step(4'd0, 1'b0, "t4_run");
            ok = m_act && (m_code == 0);
        end
        chk("t4.reach_code0", 32'(ok), 32'd1);
        chk("t4.code0", 32'(err_code), 32'd0);
        chk("t4.led_low", 32'(led), 32'd0);
        repeat (40) step(4'd0, 1'b0, "t4_tail");
        clear_all();

        // 5a: clear mid-OFF with no new error
        step(4'b0010, 1'b0, "t5_pulse");
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(4'd0, 1'b0, "t5_wait");
            ok = m_act && (m_pos == 2);
        end
        chk("t5.reach_off", 32'(ok), 32'd1);
        step(4'd0, 1'b1, "t5_clr");
        chk("t5.clr_led", 32'(led), 32'd1);
        chk("t5.clr_active", 32'(err_active), 32'd0);
        chk("t5.clr_code", 32'(err_code), 32'd0);
        step(4'd0, 1'b0, "t5_after");
        chk("t5.after_led", 32'(led), 32'd1);

        // 5b: clear together with source 3 restarts code 3
        step(4'b0001, 1'b0, "t5b_pulse");
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(4'd0, 1'b0, "t5b_wait");
            ok = m_act && (m_pos == 2);
        end
        chk("t5b.reach_off", 32'(ok), 32'd1);
        step(4'b1000, 1'b1, "t5b_clr");
        chk("t5b.active", 32'(err_active), 32'd1);
        chk("t5b.led_idle", 32'(led), 32'd1);
        chk("t5b.code_idle", 32'(err_code), 32'd0);
        step(4'd0, 1'b0, "t5b_restart");
        chk("t5b.led_low", 32'(led), 32'd0);
        chk("t5b.code3", 32'(err_code), 32'd3);
        repeat (30) step(4'd0, 1'b0, "t5b_run");

        // 6: asynchronous reset in the middle of an ON phase of code 2
        clear_all();
        step(4'b0100, 1'b0, "t6_pulse");
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(4'd0, 1'b0, "t6_wait");
            ok = m_act && (m_pos == 5);
        end
        chk("t6.reach_on", 32'(ok), 32'd1);
        @(negedge clk);
        err_in = 4'd0;
        err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6.async_led", 32'(led), 32'd1);
        chk("t6.async_active", 32'(err_active), 32'd0);
        chk("t6.async_code", 32'(err_code), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) step(4'd0, 1'b0, "t6_after");
        chk("t6.led_steady", 32'(led), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ei;
            logic       cl;
            ei = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cl = ($urandom_range(0, 59) == 0);
            step(ei, cl, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_alarm_ctrl.md
Name: led_alarm_ctrl

Overview:
- Sequencer for the board status LED.
- Collects N_SRC independent error sources into sticky pending flags and selects the lowest-index pending source.
- Drives the LED with a blink code: (index+1) blink pulses, then a steady-high gap, repeated while any error is pending.
- Sits between the subsystem error flags and the single status LED pin; replaces the single-flag toggle alarm.

Parameters:
- N_SRC, 4: number of error sources; legal range 2..16.
- L_TIME, 25_000_000: length of one LED-low or LED-high blink phase, in clk cycles; must be >= 1.
- GAP_TIME, 75_000_000: length of the LED-high gap after each code, in clk cycles; must be >= 1.
- CNT_W, 27: phase counter width; must hold max(L_TIME, GAP_TIME)-1.
- IDX_W, $clog2(N_SRC): source index width (derived localparam, not user-set).

Ports:
- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  reset; asynchronous, active-low.
- err_in  in  N_SRC  per-source error flags; level or single-cycle pulse; sampled every clk.
- err_clr  in  1  single-cycle clear of all pending flags.
- led  out  1  LED drive; 1 = lit; steady 1 means healthy.
- err_active  out  1  OR of pending flags, registered.
- err_code  out  IDX_W  index of the source whose code is currently being blinked; 0 in IDLE.

Behaviour:
- Reset values: pend=0, state=IDLE, led=1, err_active=0, err_code=0, phase counter=0, pulse counter=0.
- Pending update, each edge: if err_clr is 1, pend <= err_in; otherwise pend <= pend | err_in. A set on the same cycle as err_clr wins.
- err_active <= |pend_next, so it rises 1 cycle after err_in is sampled.
- Arbitration: lowest set bit of pend. Arbitration happens only on entry from IDLE and at GAP end. A newly pending source never truncates a code in progress.
- FSM states: IDLE, OFF, ON, GAP. All outputs are registered.
- IDLE: led=1, cnt=0. If pend != 0, then latch code=lowest index, set pulse=0, and go to OFF. led therefore falls 2 edges after err_in is sampled.
- OFF: led=0. Stay while cnt != L_TIME-1; at L_TIME-1, clear cnt and go to ON.
- ON: led=1. At cnt == L_TIME-1, clear cnt. If pulse == code, go to GAP; otherwise pulse++ and go to OFF.
- GAP: led=1. At cnt == GAP_TIME-1, clear cnt. If pend == 0, go to IDLE with err_code=0; otherwise re-arbitrate, latch the new code, set pulse=0, and go to OFF.
- Resulting period for code k: 2*(k+1)*L_TIME + GAP_TIME cycles.
- err_clr in any non-IDLE state aborts the sequence: next edge state=IDLE, led=1, cnt=0, pulse=0, err_code=0. If err_in was also set that cycle, a fresh sequence starts from IDLE on the following edge.
- Counters: cnt is CNT_W bits and pulse is IDX_W+1 bits. Both wrap only by explicit clear; no overflow is reachable with legal parameters.
- rst_n low at any time: all registers take reset values immediately (asynchronous). Operation resumes from IDLE after deassertion.

Decomposition:
- Package led_alarm_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_OFF=2'd1, ST_ON=2'd2, ST_GAP=2'd3;
  - default L_TIME and GAP_TIME constants, shared with the top-level.
- Sub-module led_alarm_prio: combinational lowest-set-bit priority encoder. Inputs N_SRC flags; outputs IDX_W index plus a valid bit. Reused by any future multi-source status logic.

Test Plan (N_SRC=4, L_TIME=4, GAP_TIME=10):
1. Reset released, err_in=0 for 200 cycles -> led=1, err_active=0, err_code=0 throughout.
2. One-cycle err_in=4'b0100 at cycle t -> err_active=1 from t+1; led low t+2..t+5, high t+6..t+9, 3 pulses ending t+25; high gap t+26..t+35; code repeats with 34-cycle period; err_code=2.
3. err_in=4'b1010 for one cycle -> err_code=1; 2 pulses (16 cycles) then 10-cycle gap, repeating; bit 3 is never shown while bit 1 is pending.
4. During code 3, pulse err_in[0] in the 2nd OFF phase -> all 4 pulses and the gap complete unchanged; the next sequence shows err_code=0 with 1 pulse.
5. err_clr mid-OFF with err_in=0 -> next edge led=1, state IDLE, err_code=0; err_active=0 on that same edge. Repeat with err_clr and err_in[3] together -> err_active stays 1 and code 3 restarts 2 edges later.
6. rst_n driven low mid-ON of code 2 -> outputs reset asynchronously before the next clk edge; after release, led stays 1 until new err_in.
